// File: rtl/duck_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | duck_pkg                                                           |
// | Shared definitions for the per-duck round controller: round state  |
// | encoding, screen coordinate widths, default ammunition and the     |
// | hitbox span test.                                                  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package duck_pkg;

  // Round state encoding
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_HIT      = 3'd2,
    ST_ESCAPING = 3'd3,
    ST_DONE     = 3'd4
  } round_state_t;

  // 160x120 playfield
  localparam int SCREEN_X_W = 8;
  localparam int SCREEN_Y_W = 7;

  localparam int DEFAULT_AMMO = 3;
  localparam int AMMO_W       = 2;
  localparam int SCORE_W      = 8;

  // True when lo <= val <= lo + size - 1. The upper bound is formed one
  // bit wider than the operands so a box touching the right/bottom edge
  // of the coordinate range never wraps back to small values.
  function automatic logic in_span(input logic [15:0] lo,
                                   input logic [15:0] size,
                                   input logic [15:0] val);
    logic [16:0] hi;
    hi = {1'b0, lo} + {1'b0, size} - 17'd1;
    return ({1'b0, val} >= {1'b0, lo}) && ({1'b0, val} <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/trigger_edge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | trigger_edge                                                       |
// | Two-flop synchroniser for an asynchronous active-low key, followed |
// | by a falling-edge detector producing a one-cycle fire pulse.       |
// | The synchronised level resets high (key released).                 |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module trigger_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic fall
);

  logic meta;
  logic sync;
  logic sync_d;

  // Synchronise the raw key and keep one extra sample for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta   <= 1'b1;
      sync   <= 1'b1;
      sync_d <= 1'b1;
    end else begin
      meta   <= key_n;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  // High for exactly one cycle after the synchronised level drops
  assign fall = sync_d & ~sync;

endmodule
`default_nettype wire

// File: rtl/duck_round_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | duck_round_ctrl                                                    |
// | Per-duck round controller feeding the movement FSM. Converts the   |
// | fire key, crosshair/duck coordinates and the slow game tick into   |
// | is_shot / escape / out_of_ammo / leave, tracks ammunition and the  |
// | escape timeout.                                                    |
// | Optional feature: define DUCK_SCORE_EN to build the 8-bit          |
// | saturating hit counter on score; otherwise score is tied to 0.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module duck_round_ctrl
  import duck_pkg::*;
#(
  parameter int AMMO         = DEFAULT_AMMO,
  parameter int ESCAPE_TICKS = 10,
  parameter int HIT_W        = 16,
  parameter int HIT_H        = 16,
  parameter int X_W          = SCREEN_X_W,
  parameter int Y_W          = SCREEN_Y_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               trigger_n,
  input  logic               tick,
  input  logic               new_round,
  input  logic [X_W-1:0]     cross_x,
  input  logic [Y_W-1:0]     cross_y,
  input  logic [X_W-1:0]     duck_x,
  input  logic [Y_W-1:0]     duck_y,
  input  logic               duck_gone,
  output logic               is_shot,
  output logic               escape,
  output logic               out_of_ammo,
  output logic               leave,
  output logic [AMMO_W-1:0]  ammo_left,
  output logic [SCORE_W-1:0] score
);

  localparam int                 TMR_W     = $clog2(ESCAPE_TICKS + 1);
  localparam logic [TMR_W-1:0]   TMR_MAX   = TMR_W'(ESCAPE_TICKS);
  localparam logic [AMMO_W-1:0]  AMMO_LOAD = AMMO_W'(AMMO);

  round_state_t       state;
  logic               fire;
  logic               tick_q;
  logic               tick_d;
  logic               tick_rise;
  logic [TMR_W-1:0]   timer;
  logic               timeout;
  logic               hit;
  logic               shot_ok;
  logic               round_load;

  trigger_edge u_trigger_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n   (trigger_n),
    .fall    (fire)
  );

  // Crosshair inside the duck's hitbox on both axes
  assign hit = in_span(16'(duck_x), 16'(HIT_W), 16'(cross_x)) &&
               in_span(16'(duck_y), 16'(HIT_H), 16'(cross_y));

  // A shot counts only while armed and with a shell in the chamber
  assign shot_ok    = fire && (state == ST_ARMED) && (ammo_left != '0);
  assign round_load = new_round && ((state == ST_IDLE) || (state == ST_DONE));
  assign timeout    = (timer == TMR_MAX);

  // Register the tick level and its previous sample for rising-edge detect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q <= 1'b0;
      tick_d <= 1'b0;
    end else begin
      tick_q <= tick;
      tick_d <= tick_q;
    end
  end

  assign tick_rise = tick_q & ~tick_d;

  // Escape timer: counts tick edges while armed, held at zero otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
    end else if (state != ST_ARMED) begin
      timer <= '0;
    end else if (tick_rise && !timeout) begin
      timer <= timer + TMR_W'(1);
    end
  end

  // Ammunition: loaded at round start, one shell per accepted shot.
  // The empty flag is its own register so it stays low before the
  // first round has ever been loaded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ammo_left   <= '0;
      out_of_ammo <= 1'b0;
    end else if (round_load) begin
      ammo_left   <= AMMO_LOAD;
      out_of_ammo <= (AMMO_LOAD == '0);
    end else if (shot_ok) begin
      ammo_left   <= ammo_left - AMMO_W'(1);
      out_of_ammo <= (ammo_left == AMMO_W'(1));
    end
  end

  // Round FSM with registered status outputs; a hit beats a timeout
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      is_shot <= 1'b0;
      escape  <= 1'b0;
      leave   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (new_round) begin
            state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (shot_ok && hit) begin
            state   <= ST_HIT;
            is_shot <= 1'b1;
          end else if ((shot_ok && (ammo_left == AMMO_W'(1))) || timeout) begin
            state  <= ST_ESCAPING;
            escape <= 1'b1;
          end
        end
        ST_HIT, ST_ESCAPING: begin
          if (duck_gone) begin
            state   <= ST_DONE;
            is_shot <= 1'b0;
            escape  <= 1'b0;
            leave   <= 1'b1;
          end
        end
        ST_DONE: begin
          if (new_round) begin
            state <= ST_ARMED;
            leave <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          is_shot <= 1'b0;
          escape  <= 1'b0;
          leave   <= 1'b0;
        end
      endcase
    end
  end

`ifdef DUCK_SCORE_EN
  logic [SCORE_W-1:0] hits;

  // Saturating hit counter, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hits <= '0;
    end else if (shot_ok && hit && (hits != {SCORE_W{1'b1}})) begin
      hits <= hits + SCORE_W'(1);
    end
  end

  assign score = hits;
`else
  assign score = '0;
`endif

endmodule
`default_nettype wire
